match_sequencer: RTL and testbench

Parametrised control sequencer for the SAD template-matching datapath, sitting between the UART front end, the image FIFO/RAM, the template ROM and the processing element (PE). It sweeps a TPL_W×TPL_H template over every vertical candidate position of an IMG_ROWS-row image strip. It drives the RAM/ROM addresses and the PE shift/reset, and reports the result through the UART send handshake. It adds two capabilities: a scan-all mode that counts matches and records the first matching row, and an abort input.

---
 rtl/match_sequencer_pkg.sv | 15 +
 rtl/match_sequencer_if.sv | 38 +++
 rtl/match_sequencer_addr_gen.sv | 47 ++++
 rtl/match_sequencer.sv | 108 ++++++++++
 tb/tb_match_sequencer.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/match_sequencer_pkg.sv
// match_pkg: shared state encoding, UART send codes and width helper for match_sequencer.
//   state_e   - sequencer FSM states
//   SEND_*    - result codes presented to the UART sender
//   clog2w()  - ceil(log2(n)) with a floor of one bit, used for all derived widths
package match_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SCAN, REPORT} state_e;
    localparam logic [1:0] SEND_OFF       = 2'd0;
    localparam logic [1:0] SEND_MATCH     = 2'd1;
    localparam logic [1:0] SEND_NOT_MATCH = 2'd2;
    function automatic int clog2w(input int n);
        int w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction
endpackage

// File: rtl/match_sequencer_if.sv
// match_sequencer_if: handshake and address bundle between the sequencer and its neighbours.
//   inputs to sequencer : start, abort, fifo_ready, pe_match, send_done
//   outputs of sequencer: rom_addr, ram_addr, pe_shift, pe_reset, send_code,
//                         match_row, match_count, busy
//   slave  modport - the sequencer itself
//   master modport - whatever drives the control inputs and observes results
interface match_sequencer_if #(
    parameter int TPL_W    = 40,
    parameter int TPL_H    = 100,
    parameter int IMG_ROWS = 480
);
    localparam int NUM_CAND = IMG_ROWS - TPL_H + 1;
    localparam int ROM_AW   = match_pkg::clog2w(TPL_W * TPL_H);
    localparam int RAM_AW   = match_pkg::clog2w(IMG_ROWS);
    localparam int ROW_W    = match_pkg::clog2w(NUM_CAND);
    localparam int CNT_W    = match_pkg::clog2w(NUM_CAND + 1);
    logic              start;
    logic              abort;
    logic              fifo_ready;
    logic              pe_match;
    logic              send_done;
    logic [ROM_AW-1:0] rom_addr;
    logic [RAM_AW-1:0] ram_addr;
    logic              pe_shift;
    logic              pe_reset;
    logic [1:0]        send_code;
    logic [ROW_W-1:0]  match_row;
    logic [CNT_W-1:0]  match_count;
    logic              busy;
    modport slave (
        input  start, abort, fifo_ready, pe_match, send_done,
        output rom_addr, ram_addr, pe_shift, pe_reset, send_code, match_row, match_count, busy
    );
    modport master (
        output start, abort, fifo_ready, pe_match, send_done,
        input  rom_addr, ram_addr, pe_shift, pe_reset, send_code, match_row, match_count, busy
    );
endinterface

// File: rtl/match_sequencer_addr_gen.sv
// template_addr_gen: walks the template pixel grid column-first within each row.
//   clk_i, rst_i - clock, synchronous active-high reset
//   clear_i      - return to pixel (0,0); wins over advance_i
//   advance_i    - step one pixel this cycle (high for every SCAN cycle)
//   rom_addr_o   - trow*TPL_W+tcol while advancing, else 0
//   trow_o       - current template row while advancing, else 0
//   pe_shift_o   - last column of a template row
//   last_o       - last pixel of the template
module template_addr_gen #(
    parameter int TPL_W = 40,
    parameter int TPL_H = 100,
    localparam int ROM_AW = match_pkg::clog2w(TPL_W * TPL_H),
    localparam int TCW    = match_pkg::clog2w(TPL_W),
    localparam int TRW    = match_pkg::clog2w(TPL_H)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    output logic [TRW-1:0]    trow_o,
    output logic              pe_shift_o,
    output logic              last_o
);
    logic [TCW-1:0] tcol_q, tcol_d;
    logic [TRW-1:0] trow_q, trow_d;
    logic           col_end;
    assign col_end = tcol_q == TCW'(TPL_W - 1);
    // trow never needs its own wrap: the last pixel always ends the candidate, which clears.
    always_comb begin
        tcol_d = clear_i ? '0 : advance_i ? (col_end ? '0 : tcol_q + TCW'(1)) : tcol_q;
        trow_d = clear_i ? '0 : (advance_i && col_end) ? trow_q + TRW'(1) : trow_q;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tcol_q <= '0;
            trow_q <= '0;
        end else begin
            tcol_q <= tcol_d;
            trow_q <= trow_d;
        end
    end
    assign rom_addr_o = advance_i ? ROM_AW'(int'(trow_q) * TPL_W + int'(tcol_q)) : '0;
    assign trow_o     = advance_i ? trow_q : '0;
    assign pe_shift_o = advance_i && col_end;
    assign last_o     = advance_i && col_end && trow_q == TRW'(TPL_H - 1);
endmodule

// File: rtl/match_sequencer.sv
// match_sequencer: sweeps a TPL_W x TPL_H template over every vertical position of an image strip.
//   clock_i, reset_i - clock, synchronous active-high reset
//   bus (slave)      - control inputs, RAM/ROM addresses, PE controls and result reporting
//   MODE 0 stops at the first matching candidate; MODE 1 scans all and counts matches.
module match_sequencer
    import match_pkg::*;
#(
    parameter int TPL_W    = 40,
    parameter int TPL_H    = 100,
    parameter int IMG_ROWS = 480,
    parameter int MODE     = 0
) (
    input  logic              clock_i,
    input  logic              reset_i,
    match_sequencer_if.slave  bus
);
    localparam int NUM_CAND = IMG_ROWS - TPL_H + 1;
    localparam int RAM_AW   = clog2w(IMG_ROWS);
    localparam int ROW_W    = clog2w(NUM_CAND);
    localparam int CNT_W    = clog2w(NUM_CAND + 1);
    localparam int TRW      = clog2w(TPL_H);
    state_e             state_q, state_d;
    logic [ROW_W-1:0]   r_q, r_d, row_q, row_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [1:0]         code_q, code_d;
    logic [TRW-1:0]     trow;
    logic               scan, busy, abort_hit, last_pix, cand_end, cand_hit, last_cand, to_report;
    assign scan      = state_q == SCAN;
    assign busy      = state_q != IDLE;
    assign abort_hit = bus.abort && busy;
    assign cand_end  = scan && (!bus.pe_match || last_pix);
    assign cand_hit  = cand_end && bus.pe_match;
    assign last_cand = r_q == ROW_W'(NUM_CAND - 1);
    assign cnt_inc   = cnt_q == CNT_W'(NUM_CAND) ? cnt_q : cnt_q + CNT_W'(1);
    template_addr_gen #(.TPL_W(TPL_W), .TPL_H(TPL_H)) u_addr (
        .clk_i      (clock_i),
        .rst_i      (reset_i),
        .clear_i    (cand_end || abort_hit),
        .advance_i  (scan),
        .rom_addr_o (bus.rom_addr),
        .trow_o     (trow),
        .pe_shift_o (bus.pe_shift),
        .last_o     (last_pix)
    );
    always_comb begin
        state_d   = state_q;
        r_d       = r_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        code_d    = code_q;
        to_report = MODE == 0 ? (cand_hit || (cand_end && last_cand)) : (cand_end && last_cand);
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = LOAD;
                r_d     = '0;
                row_d   = '0;
                cnt_d   = '0;
            end
            LOAD: if (bus.fifo_ready) state_d = SCAN;
            SCAN: begin
                // a zero count means no earlier hit this job, so this one is the first
                if (cand_hit) begin
                    cnt_d = cnt_inc;
                    if (cnt_q == '0) row_d = r_q;
                end
                if (to_report) begin
                    state_d = REPORT;
                    code_d  = (cand_hit || cnt_q != '0) ? SEND_MATCH : SEND_NOT_MATCH;
                end else if (cand_end) begin
                    r_d = r_q + ROW_W'(1);
                end
            end
            REPORT: if (bus.send_done) begin
                state_d = IDLE;
                code_d  = SEND_OFF;
            end
            default: state_d = IDLE;
        endcase
        if (abort_hit) begin
            state_d = IDLE;
            code_d  = SEND_OFF;
            r_d     = '0;
            row_d   = '0;
            cnt_d   = '0;
        end
    end
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            r_q     <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            code_q  <= SEND_OFF;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end
    assign bus.ram_addr    = scan ? RAM_AW'(int'(r_q) + int'(trow)) : '0;
    assign bus.pe_reset    = reset_i || cand_end || abort_hit;
    assign bus.send_code   = code_q;
    assign bus.match_row   = row_q;
    assign bus.match_count = cnt_q;
    assign bus.busy        = busy;
endmodule

// File: tb/tb_match_sequencer.sv
// tb_match_sequencer: drives a MODE 0 and a MODE 1 sequencer with shared stimulus against a pixel-index model.
module tb_match_sequencer;
    import match_pkg::*;
    localparam int W = 4, H = 3, ROWS = 8, NC = ROWS - H + 1;
    logic clk = 0, rst = 1, start = 0, abort = 0, fifo_ready = 0, pe_match = 0, send_done = 0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;
    match_sequencer_if #(.TPL_W(W), .TPL_H(H), .IMG_ROWS(ROWS)) if0 (), if1 ();
    assign if0.start = start;
    assign if0.abort = abort;
    assign if0.fifo_ready = fifo_ready;
    assign if0.pe_match = pe_match;
    assign if0.send_done = send_done;
    assign if1.start = start;
    assign if1.abort = abort;
    assign if1.fifo_ready = fifo_ready;
    assign if1.pe_match = pe_match;
    assign if1.send_done = send_done;
    match_sequencer #(.TPL_W(W), .TPL_H(H), .IMG_ROWS(ROWS), .MODE(0)) dut0 (
        .clock_i(clk), .reset_i(rst), .bus(if0));
    match_sequencer #(.TPL_W(W), .TPL_H(H), .IMG_ROWS(ROWS), .MODE(1)) dut1 (
        .clock_i(clk), .reset_i(rst), .bus(if1));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Model state per mode: phase 0 idle, 1 load, 2 scan, 3 report; px is the linear template pixel.
    int st[2], mr[2], px[2], code[2], row[2], cnt[2];
    bit undef[2];
    always @(negedge clk) begin
        logic [31:0] o_rom, o_ram, o_shift, o_prst, o_code, o_row, o_cnt, o_busy;
        bit scan, cend, hit, done;
        for (int k = 0; k < 2; k++) begin
            o_rom   = k == 0 ? 32'(if0.rom_addr)    : 32'(if1.rom_addr);
            o_ram   = k == 0 ? 32'(if0.ram_addr)    : 32'(if1.ram_addr);
            o_shift = k == 0 ? 32'(if0.pe_shift)    : 32'(if1.pe_shift);
            o_prst  = k == 0 ? 32'(if0.pe_reset)    : 32'(if1.pe_reset);
            o_code  = k == 0 ? 32'(if0.send_code)   : 32'(if1.send_code);
            o_row   = k == 0 ? 32'(if0.match_row)   : 32'(if1.match_row);
            o_cnt   = k == 0 ? 32'(if0.match_count) : 32'(if1.match_count);
            o_busy  = k == 0 ? 32'(if0.busy)        : 32'(if1.busy);
            scan = st[k] == 2;
            cend = scan && (!pe_match || px[k] == W * H - 1);
            chk(k ? "m1 rom_addr" : "m0 rom_addr", o_rom, scan ? px[k] : 0);
            chk(k ? "m1 ram_addr" : "m0 ram_addr", o_ram, scan ? mr[k] + px[k] / W : 0);
            chk(k ? "m1 pe_shift" : "m0 pe_shift", o_shift, 32'(scan && px[k] % W == W - 1));
            chk(k ? "m1 pe_reset" : "m0 pe_reset", o_prst, 32'(rst || cend || (abort && st[k] != 0)));
            chk(k ? "m1 busy" : "m0 busy", o_busy, 32'(st[k] != 0));
            chk(k ? "m1 send_code" : "m0 send_code", o_code, code[k]);
            if (!undef[k]) begin
                chk(k ? "m1 match_row" : "m0 match_row", o_row, row[k]);
                chk(k ? "m1 match_count" : "m0 match_count", o_cnt, cnt[k]);
            end
            if (rst) begin
                st[k] = 0; mr[k] = 0; px[k] = 0; code[k] = 0; row[k] = 0; cnt[k] = 0; undef[k] = 0;
            end else if (abort && st[k] != 0) begin
                st[k] = 0; mr[k] = 0; px[k] = 0; code[k] = 0; undef[k] = 1;
            end else if (st[k] == 0) begin
                if (start) begin st[k] = 1; mr[k] = 0; row[k] = 0; cnt[k] = 0; undef[k] = 0; end
            end else if (st[k] == 1) begin
                if (fifo_ready) st[k] = 2;
            end else if (st[k] == 2) begin
                if (cend) begin
                    hit = pe_match;
                    if (hit) begin
                        if (cnt[k] == 0) row[k] = mr[k];
                        if (cnt[k] < NC) cnt[k]++;
                    end
                    done = mr[k] == NC - 1 || (k == 0 && hit);
                    px[k] = 0;
                    if (done) begin st[k] = 3; code[k] = cnt[k] > 0 ? 1 : 2; end
                    else mr[k]++;
                end else px[k]++;
            end else if (send_done) begin
                st[k] = 0; code[k] = 0;
            end
        end
    end

    // pat 0: pe_match always 1; pat 1: always 0; pat 2: 1 only on candidates 2 and 5.
    task automatic run_job(input int pat, output int n0, output int n1);
        bit d0, d1;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0; fifo_ready = 1;
        @(posedge clk); #1 fifo_ready = 0;
        n0 = 0; n1 = 0; d0 = 0; d1 = 0;
        for (int c = 0; c < 200 && !(d0 && d1); c++) begin
            pe_match = pat == 0 ? 1'b1 : pat == 1 ? 1'b0 : (mr[1] == 2 || mr[1] == 5);
            @(negedge clk);
            d0 = d0 || if0.send_code != 0;
            d1 = d1 || if1.send_code != 0;
            if (pat == 0 && !d0) begin
                chk("rom_seq", if0.rom_addr, n0);
                chk("shift_seq", if0.pe_shift, 32'(n0 % W == W - 1));
            end
            if (pat == 0 && !d1 && n1 >= 12 && n1 < 24) begin
                chk("ram_r1", if1.ram_addr, 1 + (n1 - 12) / W);
                chk("shift_r1", if1.pe_shift, 32'((n1 - 12) % W == W - 1));
            end
            if (pat == 1 && !d0) chk("reject_reset", if0.pe_reset, 1);
            if (!d0) n0++;
            if (!d1) n1++;
            @(posedge clk); #1;
        end
        chk("report_reached", {30'd0, d0, d1}, 3);
    endtask

    task automatic end_job;
        repeat (2) @(posedge clk);
        #1 send_done = 1;
        @(posedge clk); #1 send_done = 0;
        @(negedge clk);
        chk("idle m0", if0.busy, 0);
        chk("idle m1", if1.busy, 0);
        chk("off m0", if0.send_code, 0);
    endtask

    initial begin
        int n0, n1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst pe_reset", if0.pe_reset, 1);
        chk("rst busy", if0.busy, 0);
        @(posedge clk); #1 rst = 0;
        run_job(0, n0, n1);
        chk("full n0", n0, 12); chk("full n1", n1, 72);
        chk("full code0", if0.send_code, 1); chk("full row0", if0.match_row, 0);
        chk("full cnt0", if0.match_count, 1); chk("full cnt1", if1.match_count, 6);
        chk("full code1", if1.send_code, 1);
        end_job();
        chk("held cnt1", if1.match_count, 6);
        run_job(1, n0, n1);
        chk("rej n0", n0, 6); chk("rej n1", n1, 6);
        chk("rej code0", if0.send_code, 2); chk("rej code1", if1.send_code, 2);
        chk("rej cnt0", if0.match_count, 0); chk("rej cnt1", if1.match_count, 0);
        end_job();
        run_job(2, n0, n1);
        chk("p25 n0", n0, 2 * 1 + 12); chk("p25 n1", n1, 2 * 12 + 4 * 1);
        chk("p25 code0", if0.send_code, 1); chk("p25 row0", if0.match_row, 2);
        chk("p25 cnt0", if0.match_count, 1);
        chk("p25 code1", if1.send_code, 1); chk("p25 row1", if1.match_row, 2);
        chk("p25 cnt1", if1.match_count, 2);
        end_job();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0; fifo_ready = 1;
        @(posedge clk); #1 fifo_ready = 0;
        for (int c = 0; c < 100 && !(mr[1] == 3 && px[1] == 5); c++) begin
            pe_match = mr[1] == 3;
            @(posedge clk); #1;
        end
        pe_match = 1; abort = 1;
        @(negedge clk);
        chk("abort rom", if1.rom_addr, 5); chk("abort ram", if1.ram_addr, 4);
        chk("abort prst0", if0.pe_reset, 1); chk("abort prst1", if1.pe_reset, 1);
        @(posedge clk); #1 abort = 0;
        @(negedge clk);
        chk("abort idle0", if0.busy, 0); chk("abort idle1", if1.busy, 0);
        chk("abort code1", if1.send_code, 0);
        run_job(0, n0, n1);
        chk("rescan n0", n0, 12); chk("rescan row0", if0.match_row, 0);
        end_job();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0; fifo_ready = 1;
        @(posedge clk); #1 fifo_ready = 0; pe_match = 1;
        repeat (5) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("midrst prst", if1.pe_reset, 1);
        @(negedge clk);
        chk("midrst busy", if1.busy, 0); chk("midrst rom", if1.rom_addr, 0);
        chk("midrst ram", if1.ram_addr, 0); chk("midrst cnt", if1.match_count, 0);
        chk("midrst prst hold", if1.pe_reset, 1);
        @(posedge clk); #1 rst = 0;
        for (int c = 0; c < 5000; c++) begin
            @(posedge clk); #1;
            rst        = $urandom % 400 == 0;
            start      = $urandom % 4 == 0;
            abort      = $urandom % 60 == 0;
            fifo_ready = $urandom % 3 == 0;
            pe_match   = $urandom % 16 != 0;
            send_done  = $urandom % 4 == 0;
        end
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
